// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module  : alu_op_sequencer
// Brief   : Synchronises/debounces board keys and issues one ALU op per press
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_op_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key,
  input  logic [9:0] sw,
  input  logic       op_ready,
  output logic       op_valid,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic       op_cin,
  output logic       op_reg,
  output logic [2:0] op_sel,
  output logic       op_illegal,
  output logic [7:0] op_count,
  output logic [3:0] key_db
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  logic [3:0] r_key_s1, r_key_s2;
  logic [9:0] r_sw_s1, r_sw_s2;
  logic [3:0] w_key_db;
  logic [2:0] w_opcode;

  state_t     r_state, w_state_nxt;
  logic       r_valid, w_valid_nxt;
  logic [3:0] r_a, w_a_nxt;
  logic [3:0] r_b, w_b_nxt;
  logic       r_cin, w_cin_nxt;
  logic       r_reg, w_reg_nxt;
  logic [2:0] r_sel, w_sel_nxt;
  logic       r_illegal, w_illegal_nxt;
  logic [7:0] r_count, w_count_nxt;

  // Two-flop synchronisers; released (all ones) out of reset
  always_ff @(posedge clock) begin
    if (reset) begin
      r_key_s1 <= '1;
      r_key_s2 <= '1;
      r_sw_s1  <= '1;
      r_sw_s2  <= '1;
    end else begin
      r_key_s1 <= key;
      r_key_s2 <= r_key_s1;
      r_sw_s1  <= sw;
      r_sw_s2  <= r_sw_s1;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_key_db
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             w_mismatch;

    // Raw key is active-low and the level is active-high, so equal bits disagree
    assign w_mismatch = (r_key_s2[gi] == r_level);

    always_ff @(posedge clock) begin
      if (reset) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
      end else if (!w_mismatch) begin
        r_cnt   <= '0;
      end else if (r_cnt == C_CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= ~r_level;
      end else begin
        r_cnt   <= r_cnt + C_CNT_ONE;
      end
    end

    assign w_key_db[gi] = r_level;
  end

  assign w_opcode = w_key_db[3:1];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_valid   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_cin     <= 1'b0;
      r_reg     <= 1'b0;
      r_sel     <= '0;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_valid   <= w_valid_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      r_cin     <= w_cin_nxt;
      r_reg     <= w_reg_nxt;
      r_sel     <= w_sel_nxt;
      r_illegal <= w_illegal_nxt;
      r_count   <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_valid_nxt   = r_valid;
    w_a_nxt       = r_a;
    w_b_nxt       = r_b;
    w_cin_nxt     = r_cin;
    w_reg_nxt     = r_reg;
    w_sel_nxt     = r_sel;
    w_illegal_nxt = 1'b0;
    w_count_nxt   = r_count;
    case (r_state)
      ST_IDLE: begin
        if (w_key_db[0]) begin
          if (w_opcode == 3'd7) begin
            w_illegal_nxt = 1'b1;
            w_state_nxt   = ST_HOLD;
          end else begin
            w_a_nxt     = r_sw_s2[7:4];
            w_b_nxt     = r_sw_s2[3:0];
            w_cin_nxt   = r_sw_s2[8];
            w_reg_nxt   = r_sw_s2[9];
            w_sel_nxt   = w_opcode;
            w_valid_nxt = 1'b1;
            w_state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (r_valid && op_ready) begin
          w_valid_nxt = 1'b0;
          w_count_nxt = r_count + 8'd1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Wait for release so a held key never re-issues
        if (!w_key_db[0]) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign op_valid   = r_valid;
  assign op_a       = r_a;
  assign op_b       = r_b;
  assign op_cin     = r_cin;
  assign op_reg     = r_reg;
  assign op_sel     = r_sel;
  assign op_illegal = r_illegal;
  assign op_count   = r_count;
  assign key_db     = w_key_db;

endmodule

`default_nettype wire
